// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch-side definitions: instruction codes and the PC sequencer state encoding.
package y86_pkg;

    localparam logic [3:0] IHALT = 4'h0;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    typedef enum logic [1:0] {
        RUN,
        RET_WAIT,
        HALT_PEND,
        HALTED
    } pc_seq_state_t;

endpackage

// File: rtl/pc_predict.sv
// Static next-PC predictor: jumps are predicted taken and calls go to their target;
// everything else falls through.
module pc_predict
    import y86_pkg::*;
(
    input  logic [3:0]  f_icode,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    output logic [63:0] pred_next
);

    always_comb begin
        pred_next = f_valP;
        if ((f_icode == IJXX) || (f_icode == ICALL)) begin
            pred_next = f_valC;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC controller: selects the fetch PC from the redirect/prediction paths and
// suspends fetch while a ret resolves or a halt is pending.
module pc_sequencer
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       f_icode,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,
    input  logic             f_imem_error,
    input  logic             stall,
    input  logic             M_mispred,
    input  logic [63:0]      M_valA,
    input  logic             W_ret,
    input  logic [63:0]      W_valM,
    input  logic             W_halt,
    output logic [63:0]      f_pc,
    output logic             fetch_en,
    output logic             ret_pending,
    output logic             halted,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    pc_seq_state_t state;
    pc_seq_state_t next_state;
    logic [63:0]   pred_pc;
    logic [63:0]   next_pred;
    logic [63:0]   pred_next;
    logic          ret_redirect;
    logic          live;
    logic          bubble_inc;

    pc_predict u_predict (
        .f_icode   (f_icode),
        .f_valC    (f_valC),
        .f_valP    (f_valP),
        .pred_next (pred_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            pred_pc    <= RESET_PC;
            bubble_cnt <= '0;
        end else begin
            state   <= next_state;
            pred_pc <= next_pred;
            if (bubble_inc && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        live         = (state != HALTED);
        ret_redirect = (state == RET_WAIT) && W_ret;

        // A mispredict squashes any in-flight ret, so it wins over the return address.
        f_pc = pred_pc;
        if (live && M_mispred) begin
            f_pc = M_valA;
        end else if (ret_redirect) begin
            f_pc = W_valM;
        end

        fetch_en   = (state == RUN) || (live && (M_mispred || ret_redirect));
        bubble_inc = (state == RET_WAIT) && !W_ret && !M_mispred;

        next_state = state;
        next_pred  = pred_pc;
        if (W_halt) begin
            next_state = HALTED;
        end else if (fetch_en) begin
            if (stall) begin
                // Holding on f_pc keeps a same-cycle redirect target from being lost.
                next_pred  = f_pc;
                next_state = RUN;
            end else begin
                next_pred = pred_next;
                if (f_imem_error || (f_icode == IHALT)) begin
                    next_state = HALT_PEND;
                end else if (f_icode == IRET) begin
                    next_state = RET_WAIT;
                end else begin
                    next_state = RUN;
                end
            end
        end
    end

    assign ret_pending = (state == RET_WAIT);
    assign halted      = (state == HALTED);

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-stage PC controller for the pipelined Y86-64 core. It owns the predicted-PC register and selects the fetch PC each cycle from the mispredict, return or prediction path. It runs a small FSM that suspends fetch while a ret is in flight or a halt is pending, and keeps a saturating count of return-stall cycles for performance analysis.

Parameters:
RESET_PC, 64'd0, PC loaded into pred_pc on reset.
CNT_W, 32, width of the bubble_cnt performance counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset.
f_icode  input  4  icode of the instruction fetched at f_pc this cycle.
f_valC  input  64  constant word of the fetched instruction.
f_valP  input  64  fall-through PC of the fetched instruction.
f_imem_error  input  1  fetch address invalid.
stall  input  1  F-stage stall from pipeline control.
M_mispred  input  1  jXX in M was predicted taken but not taken.
M_valA  input  64  fall-through PC of that jXX.
W_ret  input  1  ret instruction valid in W this cycle.
W_valM  input  64  return address popped by that ret.
W_halt  input  1  halt or exception committed in W.
f_pc  output  64  fetch PC for this cycle.
fetch_en  output  1  instruction memory read is valid this cycle.
ret_pending  output  1  FSM is in RET_WAIT.
halted  output  1  FSM is in HALTED.
bubble_cnt  output  CNT_W  number of cycles spent in RET_WAIT, saturating.

Behaviour:
- States: RUN, RET_WAIT, HALT_PEND, HALTED. Reset (rst_n=0 at an edge), from any state: state=RUN, pred_pc=RESET_PC, bubble_cnt=0.
- After reset: f_pc=RESET_PC, fetch_en=1, ret_pending=0, halted=0.
- f_pc is combinational. Priority order: M_mispred -> M_valA; else W_ret in RET_WAIT -> W_valM; else pred_pc.
- fetch_en=1 in RUN. fetch_en=1 in any state except HALTED during a cycle where M_mispred=1 or (RET_WAIT and W_ret=1). fetch_en=0 otherwise.
- Prediction: icode 7 (jXX) or 8 (call) -> f_valC. All other icodes -> f_valP.
- Edge update when fetch_en=1 and stall=0: pred_pc <= prediction. Next state:
  - f_imem_error=1 or f_icode=0 (halt) -> HALT_PEND.
  - f_icode=9 (ret) -> RET_WAIT.
  - otherwise -> RUN.
- Edge update when fetch_en=1 and stall=1: pred_pc <= f_pc (captures the redirect target if there was one), state <= RUN. In RUN without a redirect this is a hold.
- RET_WAIT with W_ret=0 and M_mispred=0: hold state and pred_pc. bubble_cnt increments by 1 per cycle, saturating at all-ones.
- M_mispred in RET_WAIT or HALT_PEND means the ret or halt was on the wrong path. The redirect overrides W_ret, and processing then proceeds as RUN with f_pc=M_valA.
- W_halt=1 -> HALTED at the next edge, from any state. It takes priority over all other transitions.
- HALTED is terminal until reset: fetch_en=0, pred_pc frozen, all other inputs ignored.
- Latency:
  - Redirects take effect in the same cycle (combinational f_pc).
  - Predictions take effect on the next cycle.

Decomposition:
- y86_pkg: icode constants IHALT=4'h0, IJXX=4'h7, ICALL=4'h8, IRET=4'h9, plus the pc_seq_state_t enum.
- One combinational sub-module, pc_predict: inputs f_icode, f_valC, f_valP; output pred_next.

Test Plan:
1. rst_n=0 for one edge, then rst_n=1 -> f_pc=0, fetch_en=1, halted=0, bubble_cnt=0. Reassert rst_n=0 while in RET_WAIT -> state=RUN, f_pc=0.
2. Prediction sequence:
   - f_icode=2, f_valP=10 -> next cycle f_pc=10.
   - f_icode=7, f_valC=13, f_valP=15 -> next cycle f_pc=13.
   - f_icode=8, f_valC=6 -> next cycle f_pc=6.
   - stall=1 with f_icode=7 -> f_pc unchanged.
3. Mispredict: M_mispred=1, M_valA=15 -> same-cycle f_pc=15, fetch_en=1. Repeat with stall=1 -> next cycle f_pc=15.
4. Return: f_icode=9, f_valP=12 -> RET_WAIT with fetch_en=0 for 3 cycles, then bubble_cnt=3. Then W_ret=1, W_valM=20 -> same-cycle f_pc=20, fetch_en=1, ret_pending=0 at the next edge.
5. Halt handling:
   - f_icode=0 -> HALT_PEND, fetch_en=0.
   - M_mispred=1, M_valA=40 -> f_pc=40, state RUN.
   - Halt again, then W_halt=1 -> halted=1. Stays halted despite M_mispred/W_ret until reset.
6. Simultaneous events in RET_WAIT: W_ret=1 (W_valM=20) with M_mispred=1 (M_valA=9) -> f_pc=9. bubble_cnt preset to all-ones stays saturated.
